// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for the 5-stage rv32i core: turns hazard and
// bus wait-state flags into per-stage strobes, discards a wrong-path fetch that
// overlaps a redirect, and keeps saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_hazard,
  input  logic             branch_hazard,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_exe_stall,
  output logic             id_exe_flush,
  output logic             exe_mem_stall,
  output logic             exe_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] bus_wait_cnt
);

  typedef enum logic {
    RUN,
    KILL_PEND
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [CNT_W-1:0] bus_cnt_q, bus_cnt_d;
  logic             load_evt, redir_evt, bus_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Priority decode of stall/flush strobes, counter events and next state
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_stall  = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_stall = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    load_evt      = 1'b0;
    redir_evt     = 1'b0;
    bus_evt       = 1'b0;
    state_d       = state_q;

    if (reset) begin
      // Fill the pipeline with bubbles while in reset
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      mem_wb_flush  = 1'b1;
      state_d       = RUN;
    end else if (dmem_busy) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_exe_stall  = 1'b1;
      exe_mem_stall = 1'b1;
      mem_wb_flush  = 1'b1;
      bus_evt       = 1'b1;
      // The wrong-path beat is swallowed by the held IF/ID register
      if (state_q == KILL_PEND && imem_ready) state_d = RUN;
    end else if (branch_hazard) begin
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      redir_evt     = 1'b1;
      state_d       = imem_ready ? RUN : KILL_PEND;
    end else if (state_q == KILL_PEND) begin
      if_id_flush = 1'b1;
      if (imem_ready) state_d = RUN;
    end else if (load_hazard) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exe_flush = 1'b1;
      load_evt     = 1'b1;
    end else if (!imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      bus_evt     = 1'b1;
    end
  end

  // Saturating counter next values
  always_comb begin
    load_cnt_d  = load_evt  ? sat_inc(load_cnt_q)  : load_cnt_q;
    redir_cnt_d = redir_evt ? sat_inc(redir_cnt_q) : redir_cnt_q;
    bus_cnt_d   = bus_evt   ? sat_inc(bus_cnt_q)   : bus_cnt_q;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      load_cnt_q  <= '0;
      redir_cnt_q <= '0;
      bus_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
    end
  end

  assign load_stall_cnt = load_cnt_q;
  assign redirect_cnt   = redir_cnt_q;
  assign bus_wait_cnt   = bus_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, both compared against a rule-level reference model. A second
// instance with 4-bit counters exercises saturation on the same stimulus.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset, load_hazard, branch_hazard, imem_ready, dmem_busy;

  logic pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
  logic exe_mem_stall, exe_mem_flush, mem_wb_flush;
  logic [31:0] load_stall_cnt, redirect_cnt, bus_wait_cnt;

  logic s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_exe_stall, s_id_exe_flush;
  logic s_exe_mem_stall, s_exe_mem_flush, s_mem_wb_flush;
  logic [3:0] s_load_cnt, s_redir_cnt, s_bus_cnt;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference model state
  bit          m_pend = 1'b0;
  int unsigned m_load = 0, m_redir = 0, m_bus = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .load_hazard(load_hazard),
    .branch_hazard(branch_hazard), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
    .exe_mem_stall(exe_mem_stall), .exe_mem_flush(exe_mem_flush),
    .mem_wb_flush(mem_wb_flush), .load_stall_cnt(load_stall_cnt),
    .redirect_cnt(redirect_cnt), .bus_wait_cnt(bus_wait_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .load_hazard(load_hazard),
    .branch_hazard(branch_hazard), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_exe_stall(s_id_exe_stall), .id_exe_flush(s_id_exe_flush),
    .exe_mem_stall(s_exe_mem_stall), .exe_mem_flush(s_exe_mem_flush),
    .mem_wb_flush(s_mem_wb_flush), .load_stall_cnt(s_load_cnt),
    .redirect_cnt(s_redir_cnt), .bus_wait_cnt(s_bus_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Which priority rule applies: 0 reset, 1 dmem wait, 2 redirect,
  // 3 wrong-path kill, 4 load bubble, 5 imem wait, 6 idle
  function automatic int rule_of(bit r, bit lh, bit bh, bit ir, bit db, bit pend);
    if (r)    return 0;
    if (db)   return 1;
    if (bh)   return 2;
    if (pend) return 3;
    if (lh)   return 4;
    if (!ir)  return 5;
    return 6;
  endfunction

  // Strobe vector {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
  //                id_exe_flush, exe_mem_stall, exe_mem_flush, mem_wb_flush}
  function automatic logic [7:0] strobes_of(int rule);
    case (rule)
      0:       return 8'b0010_1011;
      1:       return 8'b1101_0101;
      2:       return 8'b0010_1010;
      3:       return 8'b0010_0000;
      4:       return 8'b1100_1000;
      5:       return 8'b1010_0000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] sat15(int unsigned v);
    return (v > 15) ? 32'd15 : v;
  endfunction

  // One cycle: drive at negedge, check outputs mid-cycle, advance model
  task automatic step(input bit r, input bit lh, input bit bh, input bit ir, input bit db,
                      input string tag);
    int rule;
    logic [7:0] exp_s;
    @(negedge clk);
    reset = r; load_hazard = lh; branch_hazard = bh; imem_ready = ir; dmem_busy = db;
    #1;
    rule  = rule_of(r, lh, bh, ir, db, m_pend);
    exp_s = strobes_of(rule);
    check({tag, ".strobes"}, {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
          id_exe_flush, exe_mem_stall, exe_mem_flush, mem_wb_flush}, 32'(exp_s));
    check({tag, ".strobes4"}, {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_exe_stall,
          s_id_exe_flush, s_exe_mem_stall, s_exe_mem_flush, s_mem_wb_flush}, 32'(exp_s));
    check({tag, ".load_cnt"},  load_stall_cnt, m_load);
    check({tag, ".redir_cnt"}, redirect_cnt, m_redir);
    check({tag, ".bus_cnt"},   bus_wait_cnt, m_bus);
    check({tag, ".load_cnt4"},  32'(s_load_cnt),  sat15(m_load));
    check({tag, ".redir_cnt4"}, 32'(s_redir_cnt), sat15(m_redir));
    check({tag, ".bus_cnt4"},   32'(s_bus_cnt),   sat15(m_bus));
    case (rule)
      0: begin m_pend = 0; m_load = 0; m_redir = 0; m_bus = 0; end
      1: begin m_bus++; if (m_pend && ir) m_pend = 0; end
      2: begin m_redir++; m_pend = !ir; end
      3: if (ir) m_pend = 0;
      4: m_load++;
      5: m_bus++;
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1; load_hazard = 1'b0; branch_hazard = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0;

    // Reset for two cycles, then a clean fetch
    step(1, 0, 0, 1, 0, "reset0");
    step(1, 0, 0, 1, 0, "reset1");
    step(0, 0, 0, 1, 0, "post_reset");
    check("post_reset.direct_cnt", bus_wait_cnt, 32'd0);

    // Single load-use bubble
    step(0, 1, 0, 1, 0, "load");
    step(0, 0, 0, 1, 0, "after_load");
    check("after_load.direct_cnt", load_stall_cnt, 32'd1);

    // Redirect with outstanding fetch, two more waits, then the wrong-path beat
    step(0, 0, 1, 0, 0, "redir");
    step(0, 0, 0, 0, 0, "kill_wait1");
    step(0, 0, 0, 0, 0, "kill_wait2");
    step(0, 0, 0, 1, 0, "kill_beat");
    step(0, 0, 0, 1, 0, "after_kill");
    check("after_kill.direct_redir", redirect_cnt, 32'd1);
    check("after_kill.direct_bus", bus_wait_cnt, 32'd0);

    // dmem busy masks a simultaneous branch
    step(0, 0, 1, 1, 1, "dmem0");
    step(0, 0, 0, 1, 1, "dmem1");
    step(0, 0, 0, 1, 1, "dmem2");
    step(0, 0, 0, 1, 0, "after_dmem");
    check("after_dmem.direct_bus", bus_wait_cnt, 32'd3);
    check("after_dmem.direct_redir", redirect_cnt, 32'd1);

    // Load and branch together: branch wins
    step(0, 1, 1, 1, 0, "load_and_branch");
    step(0, 0, 0, 1, 0, "after_lb");
    check("after_lb.direct_load", load_stall_cnt, 32'd1);

    // Load hazard while imem stalls: stall IF/ID rather than flush
    step(0, 1, 0, 0, 0, "load_imem_wait");

    // 20 imem wait cycles saturate the 4-bit bus counter
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, "imem_wait");
    step(0, 0, 0, 1, 0, "after_wait");
    check("after_wait.direct_sat", 32'(s_bus_cnt), 32'd15);

    // Reset while a kill is pending drops it
    step(0, 0, 1, 0, 0, "redir_before_reset");
    step(1, 0, 0, 0, 0, "reset_in_kill");
    step(0, 0, 0, 0, 0, "run_after_reset");
    step(0, 0, 0, 1, 0, "idle_after_reset");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 6) == 0),
           "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
